// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S serialiser for the WM8731 DAC data pin (AUD_DACDAT).
//
// The codec is bit/frame master. Mono samples are accepted over a
// valid/ready handshake into a small FIFO. One sample is popped per frame,
// at the left-slot start, and is sent on both the left and right channels,
// MSB first, one BCLK after each LRCK edge (I2S timing).
//
// Optional feature macro: DAC_TX_UNDERFLOW_HOLD_EN
//   defined   -> on underflow the previously held sample is re-sent
//   undefined -> on underflow zeros are sent
//
// Ports:
//   audio_clk        AUD_BCLK; state on posedge, dac_dat register on negedge
//   reset            asynchronous, active-high
//   sample_data      two's-complement sample
//   sample_valid     sample_data valid
//   sample_ready     FIFO not full
//   dac_lrck         AUD_DACLRCK from codec (0 = left slot, 1 = right slot)
//   dac_dat          AUD_DACDAT
//   mute             send zeros; FIFO still consumed
//   fifo_level       entries held in the FIFO
//   underflow        1-cycle pulse: a frame started with the FIFO empty
//   underflow_count  saturating count of underflow pulses

module i2s_dac_tx #(
    parameter int unsigned W          = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          audio_clk,
    input  logic                          reset,
    input  logic [W-1:0]                  sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          dac_lrck,
    output logic                          dac_dat,
    input  logic                          mute,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic [7:0]                    underflow_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          armed_q;
    logic          lrck_prev_q;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  held_q, held_d;
    logic          underflow_q, underflow_d;
    logic [7:0]    ucount_q, ucount_d;
    logic          dac_dat_q;

    logic lrck_edge, left_start;
    logic fifo_empty, fifo_full;
    logic push, pop;

    // dac_lrck is launched on falling BCLK by the codec, so it is stable at
    // our posedge and needs no synchroniser.
    always_comb begin
        lrck_edge  = armed_q && (dac_lrck != lrck_prev_q);
        left_start = lrck_edge && !dac_lrck;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(FIFO_DEPTH));
        push       = sample_valid && !fifo_full;
        pop        = left_start && !fifo_empty;
    end

    // Next-state for the FIFO bookkeeping.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state for the held sample, shift register and underflow tracking.
    always_comb begin
        held_d      = held_q;
        underflow_d = 1'b0;
        ucount_d    = ucount_q;
        if (left_start) begin
            if (!fifo_empty) begin
                held_d = fifo_mem[rd_ptr_q];
            end else begin
`ifdef DAC_TX_UNDERFLOW_HOLD_EN
                held_d = held_q;
`else
                held_d = '0;
`endif
                underflow_d = 1'b1;
                if (ucount_q != 8'hFF) begin
                    ucount_d = ucount_q + 8'd1;
                end
            end
        end

        // On a right start held_d equals held_q, so both slots share this load.
        // Between edges the register shifts with zero fill; a short slot simply
        // drops its tail at the next edge.
        if (lrck_edge) begin
            shreg_d = mute ? '0 : held_d;
        end else begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            armed_q     <= 1'b0;
            lrck_prev_q <= 1'b0;
            shreg_q     <= '0;
            held_q      <= '0;
            underflow_q <= 1'b0;
            ucount_q    <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            // The first cycle after reset only captures LRCK; no edge is seen.
            armed_q     <= 1'b1;
            lrck_prev_q <= dac_lrck;
            shreg_q     <= shreg_d;
            held_q      <= held_d;
            underflow_q <= underflow_d;
            ucount_q    <= ucount_d;
        end
    end

    // Storage needs no reset: entries are only read behind the level count.
    always_ff @(posedge audio_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sample_data;
        end
    end

    // Launch on falling BCLK so the codec samples it on the next rising edge.
    always_ff @(negedge audio_clk or posedge reset) begin
        if (reset) begin
            dac_dat_q <= 1'b0;
        end else begin
            dac_dat_q <= shreg_q[W-1];
        end
    end

    assign sample_ready    = !fifo_full;
    assign fifo_level      = level_q;
    assign underflow       = underflow_q;
    assign underflow_count = ucount_q;
    assign dac_dat         = dac_dat_q;

endmodule
